// File: rtl/sram2p_init_param.sv
// sram2p_init_param: parametrised single-clock two-port SRAM (port A read,
// port B write) with a hardware initialisation sweep, write-first collision
// bypass, read-valid strobe and dropped-write indication.
// Optional macro SRAM2P_OUTREG_EN adds a second output register stage
// (read latency 2 instead of 1, VALIDA delayed to stay aligned).
module sram2p_init_param #(
  parameter int              DW       = 8,
  parameter int              AW       = 8,
  parameter logic [DW-1:0]   INIT_VAL = '0
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic [AW-1:0] ADDRA,
  input  logic          ENA,
  output logic [DW-1:0] DOUTA,
  output logic          VALIDA,
  input  logic [AW-1:0] ADDRB,
  input  logic [DW-1:0] DINB,
  input  logic          ENB,
  input  logic          WEB,
  input  logic          CLRN,
  output logic          BUSY,
  output logic          DROPB
);

  localparam int DEPTH = 2**AW;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_cnt;
  logic          r_busy;
  logic          r_dropb;
  logic [DW-1:0] r_douta;
  logic          r_valida;
  logic [DW-1:0] r_mem [DEPTH];

  // Request decode: both enables are active-low, the write strobe active-high.
  logic w_rd_req;
  logic w_wr_req;
  logic w_bypass;

  assign w_rd_req = ~ENA;
  assign w_wr_req = ~ENB & WEB;
  assign w_bypass = w_wr_req && (ADDRA == ADDRB);

  // Storage array: the sweep owns the write port in INIT, port B in READY.
  // NOTE: the array has no reset; clearing it is the sweep's job, which keeps
  // it mappable onto real RAM macros.
  always_ff @(posedge CLK) begin
    if (r_state == ST_INIT) begin
      r_mem[r_cnt] <= INIT_VAL;
    end else if (w_wr_req) begin
      r_mem[ADDRB] <= DINB;
    end
  end

  // Control FSM with registered BUSY/DROPB and the first read stage.
  // NOTE: all state here is updated with non-blocking assignments so every
  // branch sees the pre-edge values of r_state/r_cnt.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state  <= ST_INIT;
      r_cnt    <= '0;
      r_busy   <= 1'b1;
      r_dropb  <= 1'b0;
      r_douta  <= '0;
      r_valida <= 1'b0;
    end else begin
      r_dropb  <= 1'b0;
      r_valida <= 1'b0;
      case (r_state)
        ST_INIT: begin
          // Writes arriving during the sweep are discarded and flagged.
          r_dropb <= w_wr_req;
          if (r_cnt == '1) begin
            r_state <= ST_READY;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + AW'(1);
          end
        end
        ST_READY: begin
          if (w_rd_req) begin
            r_valida <= 1'b1;
            // Write-first: a same-address write forwards its data.
            r_douta  <= w_bypass ? DINB : r_mem[ADDRA];
          end
          // A clear request still lets this edge's read/write complete.
          if (!CLRN) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_INIT;
          r_cnt   <= '0;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  assign BUSY  = r_busy;
  assign DROPB = r_dropb;

`ifdef SRAM2P_OUTREG_EN
  logic [DW-1:0] r_douta_q;
  logic          r_valida_q;

  // Extra output stage: advances only on valid data, VALIDA follows it.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_douta_q  <= '0;
      r_valida_q <= 1'b0;
    end else begin
      r_valida_q <= r_valida;
      if (r_valida) begin
        r_douta_q <= r_douta;
      end
    end
  end

  assign DOUTA  = r_douta_q;
  assign VALIDA = r_valida_q;
`else
  assign DOUTA  = r_douta;
  assign VALIDA = r_valida;
`endif

endmodule

// File: doc/sram2p_init_param.md
Name: sram2p_init_param

Overview:
- Parametrised single-clock two-port SRAM model. It is the successor of the fixed 256x8 two-port RAM.
- Port A reads. Port B writes.
- Adds the following over the fixed RAM:
  - configurable width and depth
  - hardware initialisation sweep after reset and on request
  - read-during-write bypass
  - read-valid strobe
  - dropped-write indication
- Holds LDPC message/LLR storage that must start from a known value every codeword.

Parameters:
- DW, 8, data width in bits.
- AW, 8, address width; depth = 2**AW words.
- INIT_VAL, 0, DW-bit value written to every word by the init sweep.

Ports:
- CLK  input  1  single clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- ADDRA  input  AW  read address.
- ENA  input  1  read enable, active-low.
- DOUTA  output  DW  read data.
- VALIDA  output  1  high for one cycle when DOUTA carries new read data.
- ADDRB  input  AW  write address.
- DINB  input  DW  write data.
- ENB  input  1  write port enable, active-low.
- WEB  input  1  write strobe, active-high; a write is requested when ENB=0 and WEB=1.
- CLRN  input  1  synchronous clear request, active-low, sampled in READY.
- BUSY  output  1  high while the init sweep runs.
- DROPB  output  1  one-cycle pulse when a requested write is discarded.

Behaviour:
- Reset (RST_N=0, asynchronous): DOUTA=0, VALIDA=0, BUSY=1, DROPB=0, FSM=INIT, sweep counter=0. Memory contents are not reset directly.
- FSM states: INIT, READY.
- INIT state:
  - Each rising edge writes INIT_VAL to mem[counter], then increments the counter.
  - When counter = 2**AW-1 is written, the FSM goes to READY and the counter returns to 0.
  - The sweep takes exactly 2**AW cycles, counted from the first edge with RST_N=1.
  - BUSY is 1 throughout INIT. It is registered and falls on the same edge that enters READY.
  - Port A reads and port B writes are ignored during INIT.
  - A write request in INIT pulses DROPB=1 on the next cycle.
  - A read request in INIT does not assert VALIDA; DOUTA holds its value.
- READY state:
  - CLRN=0 on an edge → FSM=INIT, counter=0, BUSY=1 after that edge.
  - Any write or read on that same edge is still performed.
- Write (READY, ENB=0, WEB=1): mem[ADDRB] <= DINB on the rising edge.
- Read (READY, ENA=0):
  - DOUTA <= mem[ADDRA] on the rising edge, so latency is 1 cycle.
  - VALIDA=1 for the following cycle.
- Read idle (ENA=1): DOUTA holds its last value; VALIDA=0.
- Collision (read and write in the same cycle, ADDRA==ADDRB): write-first. DOUTA <= DINB; memory is updated with DINB.
- Different addresses in the same cycle: fully independent.
- Reset asserted mid-sweep or mid-operation: FSM returns to INIT immediately and the sweep restarts from address 0. A pending VALIDA/DROPB is cleared.
- CLRN is ignored during INIT; it does not restart a sweep already running.
- Address arithmetic: the counter is AW bits and wraps only at sweep end. No out-of-range addresses exist.

Optional Feature:
- Macro SRAM2P_OUTREG_EN.
- Defined:
  - An extra output register stage follows the read.
  - Read latency is 2 cycles; VALIDA is delayed by one cycle to stay aligned with DOUTA.
  - The collision bypass data passes through the same stage.
  - The output register resets to 0 and holds when no valid data advances.
- Undefined: read latency is 1 cycle, as above.

Test Plan:
- Defaults, release RST_N and hold ENA=0 ADDRA=0 → BUSY=1 for exactly 256 cycles, VALIDA=0 during that time. BUSY falls after edge 256. The first READY read of address 0x00 returns 0x00 with VALIDA=1 one cycle later.
- READY, write ADDRB=0x3C DINB=0xA5, then read ADDRA=0x3C the next cycle → DOUTA=0xA5 one cycle after the read (two with SRAM2P_OUTREG_EN), VALIDA aligned.
- Same cycle: write 0x10←0x77 and read 0x10 (old value 0x00) → DOUTA=0x77. A subsequent read of 0x10 → 0x77.
- Write request (ENB=0, WEB=1) at sweep cycle 5 → DROPB=1 for one cycle, memory word unaffected. After the sweep, reading that address returns INIT_VAL.
- READY, fill 0xFF←0x12, pulse CLRN=0 for one cycle → BUSY=1 for 256 cycles. Afterwards, a read of 0xFF returns 0x00.
- Assert RST_N=0 at sweep cycle 100, release → outputs at reset values immediately. The sweep restarts, and BUSY stays high for a full 256 cycles after release.
